// File: rtl/bp_mem_cmd_arbiter.sv
// bp_mem_cmd_arbiter: shares one BedRock memory command/response port among num_req_p
// requesters. Commands are arbitrated into a single registered output stage; the ID of
// each issued command is kept in an in-order tracking FIFO so that responses, which
// return in command order, are steered back to the requester that issued them.
//
// Build option: define BP_MEM_CMD_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins). Left undefined, arbitration is round-robin starting at requester 0.

module bp_mem_cmd_arbiter #(
  parameter int unsigned num_req_p         = 4,
  parameter int unsigned msg_width_p       = 576,
  parameter int unsigned max_outstanding_p = 8,
  localparam int unsigned IdW  = (num_req_p > 1) ? $clog2(num_req_p) : 1,
  localparam int unsigned PtrW = $clog2(max_outstanding_p),
  localparam int unsigned CntW = $clog2(max_outstanding_p + 1)
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [num_req_p*msg_width_p-1:0] req_cmd_i,
  input  logic [num_req_p-1:0]             req_cmd_v_i,
  output logic [num_req_p-1:0]             req_cmd_ready_o,
  output logic [msg_width_p-1:0]           mem_cmd_o,
  output logic                             mem_cmd_v_o,
  input  logic                             mem_cmd_ready_i,
  input  logic [msg_width_p-1:0]           mem_resp_i,
  input  logic                             mem_resp_v_i,
  output logic                             mem_resp_yumi_o,
  output logic [msg_width_p-1:0]           req_resp_o,
  output logic [num_req_p-1:0]             req_resp_v_o,
  input  logic [num_req_p-1:0]             req_resp_yumi_i,
  output logic [CntW-1:0]                  outstanding_o
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                 state_q, state_d;
  logic                   can_accept;
  logic                   any_v;
  logic                   grant_v;
  logic [IdW-1:0]         grant_id;
  logic [msg_width_p-1:0] grant_msg;
  logic [msg_width_p-1:0] cmd_q;

  logic [IdW-1:0]         fifo_mem_q [max_outstanding_p];
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]        cnt_q;
  logic                   fifo_nonempty;
  logic [IdW-1:0]         head;
  logic                   push, pop;

`ifndef BP_MEM_CMD_ARB_FIXED_PRIO_EN
  logic [IdW-1:0]         ptr_q;
`endif

  // No bypass from a same-cycle pop: a full FIFO blocks grants until the count drops.
  assign can_accept = ((state_q == StIdle) || mem_cmd_ready_i)
                    && (cnt_q < CntW'(max_outstanding_p));

  // Arbitration: pick the winning requester and raise its ready bit only.
  always_comb begin
    logic [IdW-1:0] idx_l;
    int             idx;
    any_v    = 1'b0;
    grant_id = '0;
    idx_l    = '0;
    idx      = 0;
`ifdef BP_MEM_CMD_ARB_FIXED_PRIO_EN
    // Scan downwards so the lowest-index valid requester is the last one written.
    for (int i = int'(num_req_p) - 1; i >= 0; i--) begin
      idx_l = IdW'(i);
      if (req_cmd_v_i[idx_l]) begin
        any_v    = 1'b1;
        grant_id = idx_l;
      end
    end
`else
    // Scan from farthest to nearest after ptr so the nearest valid requester wins.
    for (int k = int'(num_req_p); k >= 1; k--) begin
      idx   = (int'(ptr_q) + k) % int'(num_req_p);
      idx_l = IdW'(idx);
      if (req_cmd_v_i[idx_l]) begin
        any_v    = 1'b1;
        grant_id = idx_l;
      end
    end
`endif
    grant_v         = any_v && can_accept;
    req_cmd_ready_o = '0;
    if (grant_v) req_cmd_ready_o[grant_id] = 1'b1;
  end

  // Select the granted requester's command slice.
  always_comb begin
    grant_msg = '0;
    for (int i = 0; i < int'(num_req_p); i++) begin
      if (grant_id == IdW'(i)) grant_msg = req_cmd_i[i*msg_width_p +: msg_width_p];
    end
  end

  // Response steering: only the FIFO head owner sees valid.
  assign fifo_nonempty = (cnt_q != '0);
  assign head          = fifo_mem_q[rd_ptr_q];

  always_comb begin
    req_resp_v_o = '0;
    for (int i = 0; i < int'(num_req_p); i++) begin
      req_resp_v_o[i] = mem_resp_v_i && fifo_nonempty && (head == IdW'(i));
    end
    mem_resp_yumi_o = req_resp_yumi_i[head] & req_resp_v_o[head];
  end

  assign req_resp_o = mem_resp_i;
  assign push       = grant_v;
  assign pop        = mem_resp_yumi_o;

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state_q <= StIdle;
    else            state_q <= state_d;
  end

  // FSM next state: a new grant always (re)fills the output register.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant_v) state_d = StSend;
      StSend:  if (mem_cmd_ready_i && !grant_v) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    mem_cmd_v_o   = (state_q == StSend);
    mem_cmd_o     = cmd_q;
    outstanding_o = cnt_q;
  end

  // Output command register; only loads on a grant, so it holds while stalled.
  always_ff @(posedge clk_i) begin
    if (grant_v) cmd_q <= grant_msg;
  end

  // Tracking FIFO storage (contents need no reset; pointers and count do).
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem_q[wr_ptr_q] <= grant_id;
  end

  // Tracking FIFO pointers/count and arbitration pointer.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
`ifndef BP_MEM_CMD_ARB_FIXED_PRIO_EN
      ptr_q    <= IdW'(num_req_p - 1);
`endif
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
`ifndef BP_MEM_CMD_ARB_FIXED_PRIO_EN
      if (grant_v) ptr_q <= grant_id;
`endif
    end
  end

`ifndef SYNTHESIS
  // A response with nothing outstanding breaks the in-order invariant.
  resp_without_cmd_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(mem_resp_v_i && !fifo_nonempty))
    else $error("bp_mem_cmd_arbiter: memory response with no outstanding command");
`endif

endmodule

// File: tb/tb_bp_mem_cmd_arbiter.sv
// Self-checking bench for bp_mem_cmd_arbiter (default parameters). A vector table covers
// arbitration, stalls and response steering; hand sequences cover reset, hold-under-stall,
// FIFO full with simultaneous push/pop, and reset mid-transaction.

module tb_bp_mem_cmd_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned MW = 576;
  localparam int unsigned MO = 8;

  logic            clk_i = 1'b0;
  logic            reset_n_i;
  logic [N*MW-1:0] req_cmd_i;
  logic [N-1:0]    req_cmd_v_i;
  logic [N-1:0]    req_cmd_ready_o;
  logic [MW-1:0]   mem_cmd_o;
  logic            mem_cmd_v_o;
  logic            mem_cmd_ready_i;
  logic [MW-1:0]   mem_resp_i;
  logic            mem_resp_v_i;
  logic            mem_resp_yumi_o;
  logic [MW-1:0]   req_resp_o;
  logic [N-1:0]    req_resp_v_o;
  logic [N-1:0]    req_resp_yumi_i;
  logic [3:0]      outstanding_o;

  int n_checks = 0;
  int n_pass   = 0;

  bp_mem_cmd_arbiter #(
    .num_req_p         (N),
    .msg_width_p       (MW),
    .max_outstanding_p (MO)
  ) dut (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .req_cmd_i       (req_cmd_i),
    .req_cmd_v_i     (req_cmd_v_i),
    .req_cmd_ready_o (req_cmd_ready_o),
    .mem_cmd_o       (mem_cmd_o),
    .mem_cmd_v_o     (mem_cmd_v_o),
    .mem_cmd_ready_i (mem_cmd_ready_i),
    .mem_resp_i      (mem_resp_i),
    .mem_resp_v_i    (mem_resp_v_i),
    .mem_resp_yumi_o (mem_resp_yumi_o),
    .req_resp_o      (req_resp_o),
    .req_resp_v_o    (req_resp_v_o),
    .req_resp_yumi_i (req_resp_yumi_i),
    .outstanding_o   (outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] req_v;
    logic       mready;
    logic       resp_v;
    logic [3:0] yumi;
    logic [3:0] e_ready;
    logic       e_cmd_v;
    int         e_cmd_id;   // -1: mem_cmd_o not checked
    logic [3:0] e_out;
    logic [3:0] e_resp_v;
    logic       e_myumi;
  } vec_t;

  vec_t tbl [16];

  function automatic logic [MW-1:0] mk_msg(input logic [31:0] addr, input logic [7:0] tag);
    logic [MW-1:0] m;
    m           = '0;
    m[39:0]     = {tag, addr};
    m[MW-1 -: 8] = tag ^ 8'h5a;
    return m;
  endfunction

  function automatic logic [MW-1:0] slice(input int id);
    return req_cmd_i[id*MW +: MW];
  endfunction

  task automatic chk(input string name, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_default_slices();
    for (int i = 0; i < int'(N); i++) begin
      req_cmd_i[i*MW +: MW] = mk_msg(32'h1000_0000 + 32'(i * 16), 8'(i));
    end
  endtask

  task automatic idle_inputs();
    req_cmd_v_i     = '0;
    mem_cmd_ready_i = 1'b0;
    mem_resp_v_i    = 1'b0;
    req_resp_yumi_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n_i = 1'b0;
    tick();
    tick();
    reset_n_i = 1'b1;
  endtask

  initial begin
    reset_n_i  = 1'b0;
    mem_resp_i = mk_msg(32'hdead_beef, 8'hee);
    set_default_slices();
    idle_inputs();

    // Fields: req_v mready resp_v yumi | e_ready e_cmd_v e_cmd_id e_out e_resp_v e_myumi
    tbl[0]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0100, 1'b0, -1, 4'd0, 4'b0000, 1'b0};
    tbl[1]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1,  2, 4'd1, 4'b0000, 1'b0};
    tbl[2]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 4'b1000, 1'b1,  2, 4'd1, 4'b0000, 1'b0};
    tbl[3]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 4'b0001, 1'b1,  3, 4'd2, 4'b0000, 1'b0};
    tbl[4]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 4'b0010, 1'b1,  0, 4'd3, 4'b0000, 1'b0};
    tbl[5]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 4'b0100, 1'b1,  1, 4'd4, 4'b0000, 1'b0};
    tbl[6]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1,  2, 4'd5, 4'b0000, 1'b0};
    tbl[7]  = '{4'b0000, 1'b0, 1'b1, 4'b0100, 4'b0000, 1'b0, -1, 4'd5, 4'b0100, 1'b1};
    tbl[8]  = '{4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, -1, 4'd4, 4'b1000, 1'b0};
    tbl[9]  = '{4'b0000, 1'b0, 1'b1, 4'b1000, 4'b0000, 1'b0, -1, 4'd4, 4'b1000, 1'b1};
    tbl[10] = '{4'b0010, 1'b0, 1'b1, 4'b1111, 4'b0010, 1'b0, -1, 4'd3, 4'b0001, 1'b1};
    tbl[11] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1,  1, 4'd3, 4'b0000, 1'b0};
    tbl[12] = '{4'b0000, 1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0, -1, 4'd3, 4'b0010, 1'b1};
    tbl[13] = '{4'b0000, 1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0, -1, 4'd2, 4'b0100, 1'b1};
    tbl[14] = '{4'b0000, 1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0, -1, 4'd1, 4'b0010, 1'b1};
    tbl[15] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, -1, 4'd0, 4'b0000, 1'b0};

    // Reset state.
    do_reset();
    #1;
    chk("reset cmd_v", MW'(mem_cmd_v_o), MW'(1'b0));
    chk("reset outstanding", MW'(outstanding_o), MW'(0));
    chk("reset ready", MW'(req_cmd_ready_o), MW'(0));

    // Requester 2 alone with a specific address.
    req_cmd_i[2*MW +: MW] = mk_msg(32'h8000_1000, 8'h22);
    req_cmd_v_i = 4'b0100;
    #1;
    chk("single ready", MW'(req_cmd_ready_o), MW'(4'b0100));
    tick();
    req_cmd_v_i = '0;
    #1;
    chk("single cmd_v", MW'(mem_cmd_v_o), MW'(1'b1));
    chk("single cmd", mem_cmd_o, mk_msg(32'h8000_1000, 8'h22));
    chk("single outstanding", MW'(outstanding_o), MW'(1));
    chk("resp broadcast", req_resp_o, mk_msg(32'hdead_beef, 8'hee));

`ifndef BP_MEM_CMD_ARB_FIXED_PRIO_EN
    // Vector table: round-robin arbitration and in-order response steering.
    set_default_slices();
    do_reset();
    for (int r = 0; r < 16; r++) begin
      req_cmd_v_i     = tbl[r].req_v;
      mem_cmd_ready_i = tbl[r].mready;
      mem_resp_v_i    = tbl[r].resp_v;
      req_resp_yumi_i = tbl[r].yumi;
      #1;
      chk($sformatf("row%0d ready", r), MW'(req_cmd_ready_o), MW'(tbl[r].e_ready));
      chk($sformatf("row%0d cmd_v", r), MW'(mem_cmd_v_o), MW'(tbl[r].e_cmd_v));
      chk($sformatf("row%0d outstanding", r), MW'(outstanding_o), MW'(tbl[r].e_out));
      chk($sformatf("row%0d resp_v", r), MW'(req_resp_v_o), MW'(tbl[r].e_resp_v));
      chk($sformatf("row%0d mem_yumi", r), MW'(mem_resp_yumi_o), MW'(tbl[r].e_myumi));
      if (tbl[r].e_cmd_id >= 0) begin
        chk($sformatf("row%0d cmd", r), mem_cmd_o, slice(tbl[r].e_cmd_id));
      end
      tick();
    end
`endif

    // Stall: memory not ready for 5 cycles holds the command and blocks grants.
    set_default_slices();
    do_reset();
    req_cmd_v_i = 4'b0001;
    #1;
    chk("stall first ready", MW'(req_cmd_ready_o), MW'(4'b0001));
    tick();
    req_cmd_v_i = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("stall%0d ready", c), MW'(req_cmd_ready_o), MW'(0));
      chk($sformatf("stall%0d cmd_v", c), MW'(mem_cmd_v_o), MW'(1'b1));
      chk($sformatf("stall%0d cmd", c), mem_cmd_o, slice(0));
      tick();
    end
    mem_cmd_ready_i = 1'b1;
    #1;
`ifdef BP_MEM_CMD_ARB_FIXED_PRIO_EN
    chk("stall release ready", MW'(req_cmd_ready_o), MW'(4'b0001));
`else
    chk("stall release ready", MW'(req_cmd_ready_o), MW'(4'b0010));
`endif
    tick();
    req_cmd_v_i = '0;
    #1;
    chk("stall next cmd_v", MW'(mem_cmd_v_o), MW'(1'b1));
`ifdef BP_MEM_CMD_ARB_FIXED_PRIO_EN
    chk("stall next cmd", mem_cmd_o, slice(0));
`else
    chk("stall next cmd", mem_cmd_o, slice(1));
`endif

    // Fill the tracking FIFO with back-to-back grants.
    do_reset();
    req_cmd_v_i     = 4'b1111;
    mem_cmd_ready_i = 1'b1;
    for (int k = 0; k < int'(MO); k++) begin
      #1;
`ifdef BP_MEM_CMD_ARB_FIXED_PRIO_EN
      chk($sformatf("fill%0d ready", k), MW'(req_cmd_ready_o), MW'(4'b0001));
`else
      chk($sformatf("fill%0d ready", k), MW'(req_cmd_ready_o), MW'(4'b0001 << (k % 4)));
`endif
      chk($sformatf("fill%0d outstanding", k), MW'(outstanding_o), MW'(k));
      tick();
    end
    // Full: no accept, even while a pop happens this cycle.
    mem_resp_v_i    = 1'b1;
    req_resp_yumi_i = 4'b1111;
    #1;
    chk("full outstanding", MW'(outstanding_o), MW'(8));
    chk("full ready", MW'(req_cmd_ready_o), MW'(0));
    chk("full resp_v", MW'(req_resp_v_o), MW'(4'b0001));
    chk("full mem_yumi", MW'(mem_resp_yumi_o), MW'(1'b1));
    tick();
    // One slot free: grant resumes, and a simultaneous pop keeps the count.
    #1;
    chk("after pop outstanding", MW'(outstanding_o), MW'(7));
    chk("after pop ready", MW'(req_cmd_ready_o), MW'(4'b0001));
`ifdef BP_MEM_CMD_ARB_FIXED_PRIO_EN
    chk("after pop resp_v", MW'(req_resp_v_o), MW'(4'b0001));
`else
    chk("after pop resp_v", MW'(req_resp_v_o), MW'(4'b0010));
`endif
    tick();
    mem_resp_v_i    = 1'b0;
    req_resp_yumi_i = '0;
    req_cmd_v_i     = '0;
    mem_cmd_ready_i = 1'b0;
    #1;
    chk("push+pop outstanding", MW'(outstanding_o), MW'(7));
    chk("push+pop cmd_v", MW'(mem_cmd_v_o), MW'(1'b1));
    chk("push+pop cmd", mem_cmd_o, slice(0));

    // Reset mid-transaction clears everything on the next edge.
    reset_n_i = 1'b0;
    tick();
    reset_n_i = 1'b1;
    #1;
    chk("midreset cmd_v", MW'(mem_cmd_v_o), MW'(1'b0));
    chk("midreset outstanding", MW'(outstanding_o), MW'(0));
    req_cmd_v_i = 4'b1111;
    #1;
    chk("midreset ready", MW'(req_cmd_ready_o), MW'(4'b0001));
    req_cmd_v_i = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
